// File: rtl/hi_lo_muldiv_controller.sv
// HI/LO register pair with a multi-cycle shift-add multiplier and restoring divider.
// One iteration per clock, then a sign-fixup cycle that commits HI and LO together.
module hi_lo_muldiv_controller #(
    parameter int                    DATA_WIDTH        = 32,
    parameter logic [DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  read_hi_lo,
    output logic                  busy,
    output logic                  stall_request,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*W-1:0]  acc_reg, acc_next;
    logic [W-1:0]    opnd_reg, opnd_next;
    logic            is_mul_reg, is_mul_next;
    logic            neg_lo_reg, neg_lo_next;
    logic            neg_hi_reg, neg_hi_next;
    logic            div_zero_reg, div_zero_next;
    logic [W-1:0]    hi_reg, hi_next;
    logic [W-1:0]    lo_reg, lo_next;
    logic            done_reg, done_next;

    logic            signed_op, sign_a, sign_b;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      mul_sum;
    logic [W:0]      div_trial;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        acc_next      = acc_reg;
        opnd_next     = opnd_reg;
        is_mul_next   = is_mul_reg;
        neg_lo_next   = neg_lo_reg;
        neg_hi_next   = neg_hi_reg;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        done_next     = 1'b0;

        signed_op = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        sign_a    = signed_op & operand_a[W-1];
        sign_b    = signed_op & operand_b[W-1];
        abs_a     = sign_a ? -operand_a : operand_a;
        abs_b     = sign_b ? -operand_b : operand_b;

        mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
        div_trial = acc_reg[2*W-1:W-1] - {1'b0, opnd_reg};

        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (funct)
                        FUNCT_MULT, FUNCT_MULTU: begin
                            state_next    = MUL;
                            count_next    = '0;
                            opnd_next     = abs_a;
                            acc_next      = {{W{1'b0}}, abs_b};
                            is_mul_next   = 1'b1;
                            neg_lo_next   = sign_a ^ sign_b;
                            neg_hi_next   = 1'b0;
                            div_zero_next = 1'b0;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            state_next  = DIV;
                            count_next  = '0;
                            opnd_next   = abs_b;
                            is_mul_next = 1'b0;
                            if (operand_b == '0) begin
                                // Result is preloaded; fixup passes it through untouched.
                                div_zero_next = 1'b1;
                                acc_next      = {operand_a, DIV_ZERO_QUOTIENT};
                                neg_lo_next   = 1'b0;
                                neg_hi_next   = 1'b0;
                            end else begin
                                div_zero_next = 1'b0;
                                acc_next      = {{W{1'b0}}, abs_a};
                                neg_lo_next   = sign_a ^ sign_b;
                                neg_hi_next   = sign_a;
                            end
                        end
                        FUNCT_MTHI: hi_next = operand_a;
                        FUNCT_MTLO: lo_next = operand_a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_next   = {mul_sum, acc_reg[W-1:1]};
                count_next = count_reg + CW'(1);
                if (count_reg == LAST_COUNT) state_next = FIXUP;
            end
            DIV: begin
                if (div_zero_reg) begin
                    state_next = FIXUP;
                end else begin
                    acc_next[2*W-1:W] = div_trial[W] ? acc_reg[2*W-2:W-1] : div_trial[W-1:0];
                    acc_next[W-1:0]   = {acc_reg[W-2:0], ~div_trial[W]};
                    count_next        = count_reg + CW'(1);
                    if (count_reg == LAST_COUNT) state_next = FIXUP;
                end
            end
            FIXUP: begin
                if (is_mul_reg) begin
                    {hi_next, lo_next} = neg_lo_reg ? -acc_reg : acc_reg;
                end else begin
                    hi_next = neg_hi_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
                    lo_next = neg_lo_reg ? -acc_reg[W-1:0]   : acc_reg[W-1:0];
                end
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            is_mul_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            acc_reg      <= acc_next;
            opnd_reg     <= opnd_next;
            is_mul_reg   <= is_mul_next;
            neg_lo_reg   <= neg_lo_next;
            neg_hi_reg   <= neg_hi_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            done_reg     <= done_next;
        end
    end

    assign busy          = (state_reg != IDLE);
    assign stall_request = busy & (start | read_hi_lo);
    assign done          = done_reg;
    assign hi            = hi_reg;
    assign lo            = lo_reg;

endmodule

// File: tb/tb_hi_lo_muldiv_controller.sv
// Scoreboard bench for hi_lo_muldiv_controller: expected {hi,lo} queued at issue,
// popped when done pulses.
module tb_hi_lo_muldiv_controller;

    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_a, operand_b;
    logic        read_hi_lo;
    logic        busy, stall_request, done;
    logic [31:0] hi, lo;

    int checks_total  = 0;
    int checks_passed = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    hi_lo_muldiv_controller dut (
        .clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
        .operand_a(operand_a), .operand_b(operand_b), .read_hi_lo(read_hi_lo),
        .busy(busy), .stall_request(stall_request), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    // Reference: magnitude arithmetic on 64-bit integers, then sign fixup.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic sg, sa, sb;
        longint unsigned ma, mb, p, q, r;
        logic [31:0] qq, rr, na, nb;
        sg = (f == MULT) || (f == DIV);
        sa = sg & a[31];
        sb = sg & b[31];
        na = ~a + 32'd1;
        nb = ~b + 32'd1;
        ma = {32'd0, sa ? na : a};
        mb = {32'd0, sb ? nb : b};
        if (f == MULT || f == MULTU) begin
            p = ma * mb;
            if (sa ^ sb) p = ~p + 64'd1;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = ma / mb;
        r = ma % mb;
        qq = q[31:0];
        rr = r[31:0];
        if (sa ^ sb) qq = ~qq + 32'd1;
        if (sa) rr = ~rr + 32'd1;
        return {rr, qq};
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        funct = f;
        operand_a = a;
        operand_b = b;
    endtask

    // Called just after the edge that accepted the op; returns just after the edge following done.
    task automatic wait_result(input string tag, input int exp_busy, input bit chk_stall);
        int busy_cnt = 0;
        int hold_err = 0;
        int stall_err = 0;
        bit got = 1'b0;
        logic [63:0] exp;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (hi !== model_hi || lo !== model_lo) hold_err++;
                if (chk_stall && stall_request !== 1'b1) stall_err++;
            end
        end
        check_value({tag, " done seen"}, 64'(got), 64'd1);
        check_value({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check_value({tag, " hi/lo held"}, 64'(hold_err), 64'd0);
        if (chk_stall) check_value({tag, " stall"}, 64'(stall_err), 64'd0);
        if (got) begin
            check_value({tag, " sb nonempty"}, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check_value({tag, " hi:lo"}, {hi, lo}, exp);
                model_hi = exp[63:32];
                model_lo = exp[31:0];
            end
        end
        $display("op %s: busy=%0d hi=%h lo=%h", tag, busy_cnt, hi, lo);
        @(posedge clk);
        #1;
        check_value({tag, " done single"}, 64'(done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_busy);
        issue(f, a, b);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(tag, exp_busy, 1'b0);
    endtask

    task automatic run_mtxx(input string tag, input logic [5:0] f, input logic [31:0] a);
        issue(f, a, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (f == MTHI) model_hi = a; else model_lo = a;
        check_value({tag, " hi"}, 64'(hi), 64'(model_hi));
        check_value({tag, " lo"}, 64'(lo), 64'(model_lo));
        check_value({tag, " no done"}, 64'(done), 64'd0);
        check_value({tag, " idle"}, 64'(busy), 64'd0);
        $display("op %s: hi=%h lo=%h", tag, hi, lo);
    endtask

    initial begin
        logic [5:0]  ops[4];
        logic [5:0]  f;
        logic [31:0] a, b;
        ops = '{MULT, MULTU, DIV, DIVU};
        reset_n = 1'b0;
        start = 1'b0;
        funct = '0;
        operand_a = '0;
        operand_b = '0;
        read_hi_lo = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset hi", 64'(hi), 64'd0);
        check_value("reset lo", 64'(lo), 64'd0);
        check_value("reset busy", 64'(busy), 64'd0);
        check_value("reset done", 64'(done), 64'd0);
        reset_n = 1'b1;
        read_hi_lo = 1'b1;
        #1;
        check_value("idle read no stall", 64'(stall_request), 64'd0);
        read_hi_lo = 1'b0;

        run_op("MULT -2*3",     MULT,  32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 33);
        run_op("MULTU fffe*3",  MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 33);
        run_op("DIV -7/2",      DIV,   32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_op("DIVU 100/7",    DIVU,  32'd100,      32'd7, 64'h00000002_0000000E, 33);
        run_op("DIV min/-1",    DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_op("DIVU 5/0",      DIVU,  32'd5,        32'd0, 64'h00000005_FFFFFFFF, 2);
        run_op("DIV -7/0",      DIV,   32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 2);

        for (int i = 0; i < 6; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = (i == 5) ? 32'hFFFFFFFD : $urandom;
            run_op($sformatf("rand%0d f=%h a=%h b=%h", i, f, a, b), f, a, b, model(f, a, b),
                   ((f == DIV || f == DIVU) && b == 32'd0) ? 2 : 33);
        end

        run_mtxx("MTHI abcd", MTHI, 32'h0000ABCD);
        run_mtxx("MTLO 1234", MTLO, 32'h00001234);

        // Second op held at decode while busy; it is accepted once busy drops.
        issue(MULT, 32'd12345, 32'hFFFFFF00);
        exp_q.push_back(model(MULT, 32'd12345, 32'hFFFFFF00));
        @(posedge clk);
        #1;
        funct = MULTU;
        operand_a = 32'd6;
        operand_b = 32'd7;
        read_hi_lo = 1'b1;
        wait_result("stall MULT", 33, 1'b1);
        start = 1'b0;
        read_hi_lo = 1'b0;
        exp_q.push_back(64'd42);
        wait_result("reissued MULTU", 33, 1'b0);

        // Reset partway through a divide.
        issue(DIV, 32'd1000, 32'd3);
        exp_q.push_back(model(DIV, 32'd1000, 32'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("midop reset hi", 64'(hi), 64'd0);
        check_value("midop reset lo", 64'(lo), 64'd0);
        check_value("midop reset busy", 64'(busy), 64'd0);
        check_value("midop reset done", 64'(done), 64'd0);
        $display("op reset mid-DIV: hi=%h lo=%h busy=%0d", hi, lo, busy);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op("MULTU 6*7", MULTU, 32'd6, 32'd7, 64'd42, 33);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
